// File: rtl/mod_key_sched_seq.sv
// mod_key_sched_seq: iterative round-key sequencer for the modified-AES datapath.
// Accepts one NW-word key, then streams rounds 0..ROUNDS, where each round is the
// previous one passed through the word-wise RCON-modify rule.
// Optional feature macro: MKS_ROUND_SALT_EN (round number perturbs every RCON index).

module mod_key_sched_seq #(
   parameter int unsigned NW       = 4,
   parameter int unsigned ROUNDS   = 10,
   parameter int unsigned OFS_BASE = 3,
   parameter int unsigned OFS_STEP = 2,
   localparam int unsigned KW      = 32 * NW,
   localparam int unsigned RW      = $clog2(ROUNDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [KW-1:0] in_key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [KW-1:0] out_key,
   output logic [RW-1:0] out_round,
   output logic          out_last
);

   typedef enum logic {StIdle, StEmit} state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] cur, cur_nxt;
   logic [RW-1:0] rnd, rnd_nxt;
   logic [KW-1:0] mod_key;
   logic [31:0]   salt;
   logic [31:0]   word;
   logic [4:0]    idx;

   // Full 5-bit decode: indices 10..31 give zero, so no aliasing onto 0..9.
   function automatic logic [7:0] rcon(input logic [4:0] i);
      logic [7:0] r;
      unique case (i)
         5'd0:    r = 8'h01;
         5'd1:    r = 8'h02;
         5'd2:    r = 8'h04;
         5'd3:    r = 8'h08;
         5'd4:    r = 8'h10;
         5'd5:    r = 8'h20;
         5'd6:    r = 8'h40;
         5'd7:    r = 8'h80;
         5'd8:    r = 8'h1b;
         5'd9:    r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Salt for the round being produced (rnd+1), or zero in the plain build.
   always_comb begin
`ifdef MKS_ROUND_SALT_EN
      salt = 32'(rnd) + 32'd1;
`else
      salt = 32'd0;
`endif
   end

   // Next round key: per-word RCON modify; offsets summed at 32 bits, then reduced mod 32.
   always_comb begin
      mod_key = '0;
      word    = '0;
      idx     = '0;
      for (int i = 0; i < int'(NW); i++) begin
         word = cur[KW-1-32*i -: 32];
         idx  = 5'(32'(word[31:24]) + OFS_BASE + OFS_STEP * 32'(i) + salt);
         mod_key[KW-1-32*i -: 32] = word ^ {rcon(idx), 24'h000000};
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= StIdle;
         cur   <= '0;
         rnd   <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         rnd   <= rnd_nxt;
      end
   end

   // Next-state logic: accept in IDLE, advance one round per output handshake in EMIT.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      rnd_nxt   = rnd;
      unique case (state)
         StIdle: begin
            if (in_valid) begin
               cur_nxt   = in_key;
               rnd_nxt   = '0;
               state_nxt = StEmit;
            end
         end
         StEmit: begin
            if (out_ready) begin
               if (rnd == RW'(ROUNDS)) begin
                  state_nxt = StIdle;
               end else begin
                  cur_nxt = mod_key;
                  rnd_nxt = rnd + RW'(1);
               end
            end
         end
         default: state_nxt = StIdle;
      endcase
   end

   // Outputs come straight from registers; out_last is gated so it stays low once idle.
   always_comb begin
      in_ready  = (state == StIdle);
      out_valid = (state == StEmit);
      out_key   = cur;
      out_round = rnd;
      out_last  = (state == StEmit) && (rnd == RW'(ROUNDS));
   end

endmodule
